// File: rtl/md_ref_pkg.sv
// Shared types and constants for the reference batch extractor.
// Entries pair a particle id with its x/y/z position.
package md_ref_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ID_WIDTH   = 7;
  localparam int DEF_NUM_REFS   = 4;

  localparam logic [DEF_ID_WIDTH-1:0] END_OF_CELL_ID = 7'd0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    DISPATCH = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]   id;
    logic [DEF_DATA_WIDTH-1:0] x;
    logic [DEF_DATA_WIDTH-1:0] y;
    logic [DEF_DATA_WIDTH-1:0] z;
  } ref_entry_t;

endpackage

// File: rtl/ref_batch_extractor_if.sv
// Home-stream input and reference-output bundle of the batch extractor.
// The slave modport is the extractor side; master is the surrounding logic.
interface ref_batch_extractor_if
  import md_ref_pkg::*;
#(
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int PARTICLE_ID_WIDTH = DEF_ID_WIDTH,
  parameter int NUM_REFS          = DEF_NUM_REFS
);
  localparam int SLOT_WIDTH = $clog2(NUM_REFS);

  logic                         phase;
  logic                         prev_phase;
  logic                         home_valid;
  logic [DATA_WIDTH-1:0]        home_pos_x;
  logic [DATA_WIDTH-1:0]        home_pos_y;
  logic [DATA_WIDTH-1:0]        home_pos_z;
  logic [PARTICLE_ID_WIDTH-1:0] particle_id;
  logic                         ref_ready;
  logic                         ref_valid;
  logic [PARTICLE_ID_WIDTH-1:0] ref_id;
  logic [DATA_WIDTH-1:0]        ref_x;
  logic [DATA_WIDTH-1:0]        ref_y;
  logic [DATA_WIDTH-1:0]        ref_z;
  logic [SLOT_WIDTH-1:0]        ref_slot;
  logic [SLOT_WIDTH:0]          ref_count;
  logic                         busy;
  logic                         batch_done;

  modport master (
    output phase, prev_phase, home_valid, home_pos_x, home_pos_y, home_pos_z,
           particle_id, ref_ready,
    input  ref_valid, ref_id, ref_x, ref_y, ref_z, ref_slot, ref_count,
           busy, batch_done
  );

  modport slave (
    input  phase, prev_phase, home_valid, home_pos_x, home_pos_y, home_pos_z,
           particle_id, ref_ready,
    output ref_valid, ref_id, ref_x, ref_y, ref_z, ref_slot, ref_count,
           busy, batch_done
  );

endinterface

// File: rtl/ref_bank.sv
// Register file holding one batch of reference entries.
// One write port, one registered read port with load enable, async clear.
module ref_bank
  import md_ref_pkg::*;
#(
  parameter int  NUM_REFS = DEF_NUM_REFS,
  parameter type entry_t  = ref_entry_t
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we_i,
  input  logic [$clog2(NUM_REFS)-1:0] waddr_i,
  input  entry_t                      wdata_i,
  input  logic                        re_i,
  input  logic [$clog2(NUM_REFS)-1:0] raddr_i,
  output entry_t                      rdata_o
);

  entry_t bank_q [NUM_REFS];
  entry_t rdata_q;

  // Storage array and read-data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REFS; i++) begin
        bank_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        bank_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
        rdata_q <= bank_q[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ref_batch_extractor.sv
// Captures a batch of reference particles from the home-cell stream on a phase
// edge, then hands them to the force pipeline one per valid/ready handshake.
module ref_batch_extractor
  import md_ref_pkg::*;
#(
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int PARTICLE_ID_WIDTH = DEF_ID_WIDTH,
  parameter int NUM_REFS          = DEF_NUM_REFS
) (
  input logic                   clk,
  input logic                   rst,
  ref_batch_extractor_if.slave  bus
);

  localparam int SLOT_WIDTH = $clog2(NUM_REFS);
  localparam int CNT_WIDTH  = SLOT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  LAST_SLOT = CNT_WIDTH'(NUM_REFS - 1);
  localparam logic [SLOT_WIDTH-1:0] SLOT_ONE  = SLOT_WIDTH'(1);

  typedef struct packed {
    logic [PARTICLE_ID_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0]        x;
    logic [DATA_WIDTH-1:0]        y;
    logic [DATA_WIDTH-1:0]        z;
  } entry_t;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  wcnt_q, wcnt_d;
  logic [SLOT_WIDTH-1:0] rd_q, rd_d;
  logic                  pending_q, pending_d;
  logic [CNT_WIDTH-1:0]  ref_count_q, ref_count_d;
  logic                  ref_valid_q, ref_valid_d;
  logic                  busy_q, busy_d;
  logic                  batch_done_q, batch_done_d;

  logic   phase_edge_s, is_eoc_s, hs_s, last_s, we_s;
  entry_t wdata_s, rdata_s;

  assign phase_edge_s = bus.phase ^ bus.prev_phase;
  assign is_eoc_s     = (bus.particle_id == PARTICLE_ID_WIDTH'(END_OF_CELL_ID));
  assign hs_s         = ref_valid_q & bus.ref_ready;
  assign last_s       = ({1'b0, rd_q} == (ref_count_q - CNT_ONE));
  assign wdata_s      = '{id: bus.particle_id, x: bus.home_pos_x,
                          y: bus.home_pos_y, z: bus.home_pos_z};

  // State and control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      rd_q         <= '0;
      pending_q    <= 1'b0;
      ref_count_q  <= '0;
      ref_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      batch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      rd_q         <= rd_d;
      pending_q    <= pending_d;
      ref_count_q  <= ref_count_d;
      ref_valid_q  <= ref_valid_d;
      busy_q       <= busy_d;
      batch_done_q <= batch_done_d;
    end
  end

  // Next-state, write count, read pointer and pending-edge tracking
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rd_d      = rd_q;
    pending_d = pending_q;
    we_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (phase_edge_s || pending_q) begin
          state_d   = CAPTURE;
          wcnt_d    = '0;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        if (phase_edge_s) begin
          wcnt_d = '0;
        end else if (bus.home_valid && !is_eoc_s) begin
          we_s   = 1'b1;
          wcnt_d = wcnt_q + CNT_ONE;
          if (wcnt_q == LAST_SLOT) begin
            state_d = DISPATCH;
          end else begin
            state_d = CAPTURE;
          end
        end else if (bus.home_valid) begin
          if (wcnt_q != '0) begin
            state_d = DISPATCH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = CAPTURE;
        end
      end
      DISPATCH: begin
        if (phase_edge_s) begin
          pending_d = 1'b1;
        end else begin
          pending_d = pending_q;
        end
        if (hs_s && last_s) begin
          rd_d = '0;
          // A phase edge seen during dispatch starts the next capture at once
          if (phase_edge_s || pending_q) begin
            state_d   = CAPTURE;
            wcnt_d    = '0;
            pending_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (hs_s) begin
          rd_d = rd_q + SLOT_ONE;
        end else begin
          rd_d = rd_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    ref_valid_d  = (state_d == DISPATCH);
    busy_d       = (state_d != IDLE);
    batch_done_d = 1'b0;
    ref_count_d  = ref_count_q;
    if (state_q == CAPTURE && state_d == IDLE) begin
      batch_done_d = 1'b1;
    end else if (state_q == DISPATCH && state_d != DISPATCH) begin
      batch_done_d = 1'b1;
    end else begin
      batch_done_d = 1'b0;
    end
    if (state_q != CAPTURE && state_d == CAPTURE) begin
      ref_count_d = '0;
    end else if (state_q == CAPTURE && state_d == DISPATCH) begin
      ref_count_d = wcnt_d;
    end else begin
      ref_count_d = ref_count_q;
    end
  end

  ref_bank #(
    .NUM_REFS (NUM_REFS),
    .entry_t  (entry_t)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_s),
    .waddr_i (wcnt_q[SLOT_WIDTH-1:0]),
    .wdata_i (wdata_s),
    .re_i    (ref_valid_d),
    .raddr_i (rd_d),
    .rdata_o (rdata_s)
  );

  assign bus.ref_valid  = ref_valid_q;
  assign bus.ref_id     = rdata_s.id;
  assign bus.ref_x      = rdata_s.x;
  assign bus.ref_y      = rdata_s.y;
  assign bus.ref_z      = rdata_s.z;
  assign bus.ref_slot   = rd_q;
  assign bus.ref_count  = ref_count_q;
  assign bus.busy       = busy_q;
  assign bus.batch_done = batch_done_q;

endmodule
